l1i_loader: RTL and testbench
=============================

Name: l1i_loader

Overview:
- Writer side of the L1 instruction cache fill port. Receives a byte stream from the host link and assembles it into 60-bit instruction bundles.
- Writes each bundle into the i-cache through its writeEnable/writeAddress/instruction port.
- Holds the fetch pipeline in reset until a complete, checksummed image has been loaded.

Parameters:
- ADDR_WIDTH, 16, cache write address width.
- INSTR_WIDTH, 60, bundle width (two 30-bit instructions).
- BYTES_PER_BUNDLE, 8, stream bytes per bundle. The top 64-INSTR_WIDTH bits are discarded.
- NUM_CACHE_ENTRIES, 1000, number of cache lines; used for the range check.

Ports:
- clock_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- rxData_i  in  8  stream byte
- rxValid_i  in  1  byte valid
- rxReady_o  out  1  loader accepts a byte this cycle (transfer = rxValid_i & rxReady_o)
- writeEnable_o  out  1  cache write strobe
- writeAddress_o  out  16  cache line address
- instruction_o  out  60  bundle to write
- coreReset_o  out  1  drives the fetch/decode reset_i
- done_o  out  1  image loaded and checksum good
- error_o  out  1  sticky load error

Behaviour:
- Reset (reset_i=1 at clock edge):
  - state=HDR, all counters and checksum = 0.
  - rxReady_o=0, writeEnable_o=0, writeAddress_o=0, instruction_o=0.
  - coreReset_o=1, done_o=0, error_o=0.
  - reset_i overrides any state, including mid-bundle and ERR. A partially loaded image is abandoned; lines already written stay written.
- Frame format, MSB first:
  - addr[15:8], addr[7:0], count[15:8], count[7:0].
  - count × 8 data bytes.
  - 1 checksum byte = XOR of all 4 header bytes and all data bytes.
- HDR:
  - rxReady_o=1. Shifts in 4 bytes, XOR-accumulating each.
  - After the 4th byte, go to CHECK.
  - Accepting the first header byte while in DONE re-enters HDR: coreReset_o=1, done_o=0.
- CHECK (1 cycle, rxReady_o=0):
  - If addr+count > NUM_CACHE_ENTRIES (17-bit compare, no wrap), go to ERR.
  - Else if count==0, go to SUM.
  - Else load line pointer = addr, go to DATA.
- DATA:
  - rxReady_o=1. Shifts bytes into a 64-bit assembly register and XORs each into the checksum.
  - On the 8th byte, go to WRITE.
- WRITE (exactly 1 cycle, rxReady_o=0):
  - writeEnable_o=1, writeAddress_o=line pointer, instruction_o=assembly[59:0].
  - Pointer increments, remaining count decrements.
  - If remaining becomes 0, go to SUM; else go to DATA.
  - writeEnable_o is 0 in every other state/cycle. Address and data hold their last values when not writing.
- SUM:
  - rxReady_o=1. Accept 1 byte.
  - If it equals the accumulated XOR, go to DONE; else go to ERR.
- DONE: coreReset_o=0, done_o=1, rxReady_o=1 (the next byte starts a new frame as header byte 0).
- ERR:
  - error_o=1, coreReset_o=1, done_o=0.
  - rxReady_o=1; all bytes are discarded.
  - Exit only via reset_i.
- rxValid_i=0 stalls any receiving state indefinitely with no timeout; counters hold.
- rxReady_o is a registered output driven from the state only, not from rxValid_i.
- Latency: last data byte of a bundle accepted at edge N → writeEnable_o high in cycle N+1. Minimum 9 cycles per bundle.
- Pointer arithmetic is 16-bit. The range check guarantees no wrap on write.

Test Plan:
- Reset with rxValid_i=0 → coreReset_o=1, rxReady_o=1 after the first post-reset cycle, writeEnable_o never pulses, done_o=0, error_o=0.
- Frame addr=0x0003, count=2, bundles 0x0123456789ABCDEF and 0xF000000000000001, correct checksum → two single-cycle writes: (3, 0x123456789ABCDEF) then (4, 0x000000000000001). Then done_o=1 and coreReset_o=0.
- Same frame with rxValid_i toggled 0/1 every cycle → identical writes and final state; no byte lost or duplicated.
- Frame addr=998, count=3 → no writes, error_o=1 after CHECK, rxReady_o=1, coreReset_o stays 1. A subsequent reset_i clears error_o.
- Valid frame with checksum byte XORed by 0x01 → both writes still occur, error_o=1, done_o=0.
- count=0 frame (addr=0x0010, checksum 0x10) → no writes, done_o=1. Then a second frame is accepted: coreReset_o reasserts on its first byte. Separately, reset_i pulsed after 5 of 8 data bytes → state HDR, no write issued for the partial bundle.

Source files
------------

// File: rtl/l1i_loader_if.sv
// Fill-port bundle between the host byte stream, the loader and the i-cache write port.
// The master drives the byte stream; the loader (slave) drives the cache write and status signals.
interface l1i_loader_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 60
);
    logic [7:0]             rxData_i;
    logic                   rxValid_i;
    logic                   rxReady_o;
    logic                   writeEnable_o;
    logic [ADDR_WIDTH-1:0]  writeAddress_o;
    logic [INSTR_WIDTH-1:0] instruction_o;
    logic                   coreReset_o;
    logic                   done_o;
    logic                   error_o;

    modport master (
        output rxData_i, rxValid_i,
        input  rxReady_o, writeEnable_o, writeAddress_o, instruction_o,
        input  coreReset_o, done_o, error_o
    );

    modport slave (
        input  rxData_i, rxValid_i,
        output rxReady_o, writeEnable_o, writeAddress_o, instruction_o,
        output coreReset_o, done_o, error_o
    );
endinterface

// File: rtl/l1i_loader.sv
// Assembles a checksummed byte-stream image into 60-bit bundles, writes them into the
// i-cache and releases the fetch pipeline from reset once the whole image checks out.
module l1i_loader #(
    parameter int ADDR_WIDTH        = 16,
    parameter int INSTR_WIDTH       = 60,
    parameter int BYTES_PER_BUNDLE  = 8,
    parameter int NUM_CACHE_ENTRIES = 1000
) (
    input  logic          clock_i,
    input  logic          reset_i,
    l1i_loader_if.slave   bus
);
    // state | meaning
    // HDR   | shifting in addr/count header bytes
    // CHECK | range check on addr+count
    // DATA  | shifting in bundle bytes
    // WRITE | one-cycle cache write strobe
    // SUM   | comparing the checksum byte
    // DONE  | image good, core released
    // ERR   | sticky error, bytes discarded
    typedef enum logic [2:0] {HDR, CHECK, DATA, WRITE, SUM, DONE, ERR} state_t;

    localparam int ASM_WIDTH = INSTR_WIDTH - 8;
    localparam logic [2:0] LAST_DATA_BYTE = 3'(BYTES_PER_BUNDLE - 1);
    localparam logic [16:0] LIMIT = 17'(NUM_CACHE_ENTRIES);

    state_t                 state_q;
    logic [31:0]            hdr_q;
    logic [ASM_WIDTH-1:0]   asm_q;
    logic [7:0]             sum_q;
    logic [2:0]             byte_cnt_q;
    logic [ADDR_WIDTH-1:0]  ptr_q;
    logic [15:0]            remain_q;
    logic                   rdy_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  waddr_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic                   core_rst_q;
    logic                   done_q;
    logic                   err_q;

    logic        xfer;
    logic [15:0] hdr_addr;
    logic [15:0] hdr_count;
    logic [16:0] range_end;

    always_comb begin
        xfer      = bus.rxValid_i & rdy_q;
        hdr_addr  = hdr_q[31:16];
        hdr_count = hdr_q[15:0];
        range_end = {1'b0, hdr_addr} + {1'b0, hdr_count};
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= HDR;
            hdr_q      <= '0;
            asm_q      <= '0;
            sum_q      <= '0;
            byte_cnt_q <= '0;
            ptr_q      <= '0;
            remain_q   <= '0;
            rdy_q      <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            instr_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            rdy_q <= 1'b1;
            unique case (state_q)
                HDR: begin
                    if (xfer) begin
                        hdr_q <= {hdr_q[23:0], bus.rxData_i};
                        sum_q <= sum_q ^ bus.rxData_i;
                        if (byte_cnt_q == 3'd3) begin
                            byte_cnt_q <= '0;
                            state_q    <= CHECK;
                            rdy_q      <= 1'b0;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end
                CHECK: begin
                    if (range_end > LIMIT) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                    end else if (hdr_count == 16'd0) begin
                        state_q <= SUM;
                    end else begin
                        ptr_q    <= hdr_addr[ADDR_WIDTH-1:0];
                        remain_q <= hdr_count;
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (xfer) begin
                        asm_q <= {asm_q[ASM_WIDTH-9:0], bus.rxData_i};
                        sum_q <= sum_q ^ bus.rxData_i;
                        if (byte_cnt_q == LAST_DATA_BYTE) begin
                            // Outputs are registered, so the strobe is raised on entry to WRITE.
                            byte_cnt_q <= '0;
                            state_q    <= WRITE;
                            rdy_q      <= 1'b0;
                            we_q       <= 1'b1;
                            waddr_q    <= ptr_q;
                            instr_q    <= {asm_q, bus.rxData_i};
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end
                end
                WRITE: begin
                    ptr_q    <= ptr_q + 1'b1;
                    remain_q <= remain_q - 16'd1;
                    state_q  <= (remain_q == 16'd1) ? SUM : DATA;
                end
                SUM: begin
                    if (xfer) begin
                        if (bus.rxData_i == sum_q) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (xfer) begin
                        // This byte is header byte 0 of the next frame.
                        hdr_q      <= {hdr_q[23:0], bus.rxData_i};
                        sum_q      <= bus.rxData_i;
                        byte_cnt_q <= 3'd1;
                        state_q    <= HDR;
                        core_rst_q <= 1'b1;
                        done_q     <= 1'b0;
                    end
                end
                ERR: begin
                    err_q <= 1'b1;
                end
                default: begin
                    state_q <= ERR;
                    err_q   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rxReady_o      = rdy_q;
    assign bus.writeEnable_o  = we_q;
    assign bus.writeAddress_o = waddr_q;
    assign bus.instruction_o  = instr_q;
    assign bus.coreReset_o    = core_rst_q;
    assign bus.done_o         = done_q;
    assign bus.error_o        = err_q;
endmodule

// File: tb/tb_l1i_loader.sv
// Scoreboard bench for l1i_loader: expected cache writes are queued as frames are sent
// and popped by a monitor on every writeEnable_o pulse.
module tb_l1i_loader;
    logic clk = 1'b0;
    logic reset_i;

    l1i_loader_if bus ();

    l1i_loader dut (
        .clock_i (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [59:0] instr;
    } wr_t;

    wr_t         exp_q[$];
    logic [63:0] bundles[$];
    int          checks = 0;
    int          passed = 0;

    always @(negedge clk) begin
        if (bus.writeEnable_o === 1'b1) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_write: got addr=%h instr=%h, required no write",
                         bus.writeAddress_o, bus.instruction_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.writeAddress_o !== e.addr || bus.instruction_o !== e.instr)
                    $display("FAIL write_data: got addr=%h instr=%h, required addr=%h instr=%h",
                             bus.writeAddress_o, bus.instruction_o, e.addr, e.instr);
                else
                    passed++;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            bus.rxValid_i = 1'b0;
            @(negedge clk);
        end
        bus.rxData_i  = b;
        bus.rxValid_i = 1'b1;
        n = 0;
        while (bus.rxReady_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL send_byte_timeout: rxReady_o=%b, required 1 within 200 cycles", bus.rxReady_o);
        end
        @(negedge clk);
        bus.rxValid_i = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] addr, input logic [15:0] cnt,
                              input logic [7:0] sum_mask, input int gap, input bit expect_write);
        logic [7:0]  hb[4];
        logic [7:0]  s;
        logic [63:0] bw;
        wr_t         w;
        hb = '{addr[15:8], addr[7:0], cnt[15:8], cnt[7:0]};
        s  = 8'h00;
        for (int i = 0; i < 4; i++) begin
            send_byte(hb[i], gap);
            s ^= hb[i];
        end
        for (int k = 0; k < int'(cnt); k++) begin
            bw = bundles[k];
            if (expect_write) begin
                w.addr  = addr + 16'(k);
                w.instr = bw[59:0];
                exp_q.push_back(w);
            end
            for (int j = 0; j < 8; j++) begin
                send_byte(bw[63-8*j -: 8], gap);
                s ^= bw[63-8*j -: 8];
            end
        end
        send_byte(s ^ sum_mask, gap);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_drain: %0d writes outstanding, required 0", name, exp_q.size());
        else
            passed++;
    endtask

    task automatic check_status(input string name, input logic done_e, input logic err_e,
                                input logic crst_e);
        checks++;
        if (bus.done_o !== done_e || bus.error_o !== err_e || bus.coreReset_o !== crst_e)
            $display("FAIL %s_status: got done=%b error=%b coreReset=%b, required done=%b error=%b coreReset=%b",
                     name, bus.done_o, bus.error_o, bus.coreReset_o, done_e, err_e, crst_e);
        else
            passed++;
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_i       = 1'b1;
        bus.rxValid_i = 1'b0;
        bus.rxData_i  = 8'h00;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rxReady_o !== 1'b0 || bus.writeEnable_o !== 1'b0 ||
            bus.writeAddress_o !== 16'h0 || bus.instruction_o !== 60'h0)
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h instr=%h, required all 0",
                     bus.rxReady_o, bus.writeEnable_o, bus.writeAddress_o, bus.instruction_o);
        else
            passed++;
        check_status("reset", 1'b0, 1'b0, 1'b1);
        reset_i = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rxReady_o !== 1'b1)
            $display("FAIL reset_ready: got rxReady_o=%b, required 1", bus.rxReady_o);
        else
            passed++;
        repeat (5) @(negedge clk);
        check_status("idle", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_valid_frame();
        bundles = '{64'h0123456789ABCDEF, 64'hF000000000000001};
        send_frame(16'h0003, 16'd2, 8'h00, 0, 1'b1);
        wait_drain("valid");
        check_status("valid", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_stall_frame();
        do_reset();
        bundles = '{64'h0123456789ABCDEF, 64'hF000000000000001};
        send_frame(16'h0003, 16'd2, 8'h00, 1, 1'b1);
        wait_drain("stall");
        check_status("stall", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_range_error();
        do_reset();
        send_byte(8'h03, 0);
        send_byte(8'hE6, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        @(negedge clk);
        check_status("range", 1'b0, 1'b1, 1'b1);
        checks++;
        if (bus.rxReady_o !== 1'b1)
            $display("FAIL range_ready: got rxReady_o=%b, required 1", bus.rxReady_o);
        else
            passed++;
        for (int i = 0; i < 9; i++) send_byte(8'(i * 17), 0);
        wait_drain("range");
        check_status("range_discard", 1'b0, 1'b1, 1'b1);
        do_reset();
        check_status("range_cleared", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_bad_checksum();
        do_reset();
        bundles = '{64'h0123456789ABCDEF, 64'hF000000000000001};
        send_frame(16'h0003, 16'd2, 8'h01, 0, 1'b1);
        wait_drain("badsum");
        check_status("badsum", 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_zero_count_and_restart();
        logic [7:0]  s;
        logic [63:0] bw;
        wr_t         w;
        do_reset();
        bundles = {};
        send_frame(16'h0010, 16'd0, 8'h00, 0, 1'b0);
        wait_drain("zero");
        check_status("zero", 1'b1, 1'b0, 1'b0);
        bw = 64'hA5A5_0F0F_1234_5678;
        s  = 8'h00 ^ 8'h05 ^ 8'h00 ^ 8'h01;
        send_byte(8'h00, 0);
        check_status("restart_first_byte", 1'b0, 1'b0, 1'b1);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        w.addr  = 16'h0005;
        w.instr = bw[59:0];
        exp_q.push_back(w);
        for (int j = 0; j < 8; j++) begin
            send_byte(bw[63-8*j -: 8], 0);
            s ^= bw[63-8*j -: 8];
        end
        send_byte(s, 0);
        wait_drain("restart");
        check_status("restart_done", 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_bundle();
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h20, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i), 0);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        repeat (12) @(negedge clk);
        wait_drain("midreset");
        checks++;
        if (bus.rxReady_o !== 1'b1)
            $display("FAIL midreset_ready: got rxReady_o=%b, required 1", bus.rxReady_o);
        else
            passed++;
        check_status("midreset", 1'b0, 1'b0, 1'b1);
        bundles = '{64'h1111_2222_3333_4444};
        send_frame(16'h0021, 16'd1, 8'h00, 0, 1'b1);
        wait_drain("after_midreset");
        check_status("after_midreset", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_valid_frame();
        test_stall_frame();
        test_range_error();
        test_bad_checksum();
        test_zero_count_and_restart();
        test_reset_mid_bundle();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
